// File: rtl/lt24_hires_led_out_if.sv
// Avalon-MM slave bus bundle for the LED output port: address, select, write strobe and data.
// The master modport belongs to the CPU side, the slave modport to lt24_hires_led_out.
interface lt24_hires_led_out_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/lt24_hires_led_out.sv
// LED output port: DATA register with set/clear strobes, per-bit blink engine and registered readback.
// Define LT24_LED_OUT_PWM_EN to add an 8-bit DUTY register at address 6 that gates all outputs with PWM.
module lt24_hires_led_out #(
    parameter int               WIDTH       = 8,
    parameter int               CNT_W       = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    lt24_hires_led_out_if.slave  bus,
    output logic [WIDTH-1:0]     out_port
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [CNT_W-1:0] w_wd_period;
    logic             w_period_wr;
    logic             w_unused;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_blink_en;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic [WIDTH-1:0] r_out;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_pre;
    logic [WIDTH-1:0] w_final;
    logic [31:0]      w_rd_mux;

    assign w_wr        = bus.chipselect & ~bus.write_n;
    assign w_wd        = bus.writedata[WIDTH-1:0];
    assign w_wd_period = bus.writedata[CNT_W-1:0];
    assign w_period_wr = w_wr && (bus.address == 3'd2);
    assign w_unused    = ^bus.writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= RESET_VALUE;
            r_blink_en <= '0;
        end else if (w_wr) begin
            case (bus.address)
                3'd0:    r_data     <= w_wd;
                3'd1:    r_blink_en <= w_wd;
                3'd4:    r_data     <= r_data | w_wd;
                3'd5:    r_data     <= r_data & ~w_wd;
                default: ;
            endcase
        end
    end

    // A PERIOD write restarts the half-cycle and beats any expiry landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period <= '0;
            r_cnt    <= '0;
            r_phase  <= 1'b1;
        end else if (w_period_wr) begin
            r_period <= w_wd_period;
            r_cnt    <= (w_wd_period == '0) ? '0 : (w_wd_period - CNT_ONE);
            r_phase  <= 1'b1;
        end else if (r_period == '0) begin
            r_cnt    <= '0;
            r_phase  <= 1'b1;
        end else if (r_cnt == '0) begin
            r_cnt    <= r_period - CNT_ONE;
            r_phase  <= ~r_phase;
        end else begin
            r_cnt    <= r_cnt - CNT_ONE;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_blink
            assign w_pre[gi] = r_data[gi] & (~r_blink_en[gi] | r_phase);
        end
    endgenerate

`ifdef LT24_LED_OUT_PWM_EN
    logic [7:0] r_duty;
    logic [7:0] r_pwm_cnt;
    logic       w_pwm_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty    <= 8'hFF;
            r_pwm_cnt <= 8'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (w_wr && (bus.address == 3'd6))
                r_duty <= bus.writedata[7:0];
        end
    end

    // DUTY = 0xFF means fully on; the compare alone would drop one clock in 256.
    assign w_pwm_on = (r_pwm_cnt < r_duty) | (r_duty == 8'hFF);
    assign w_final  = w_pre & {WIDTH{w_pwm_on}};
`else
    assign w_final  = w_pre;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            3'd0:    w_rd_mux = 32'(r_data);
            3'd1:    w_rd_mux = 32'(r_blink_en);
            3'd2:    w_rd_mux = 32'(r_period);
            3'd3:    w_rd_mux = {30'd0, (r_period != '0), r_phase};
`ifdef LT24_LED_OUT_PWM_EN
            3'd6:    w_rd_mux = {24'd0, r_duty};
`endif
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out      <= RESET_VALUE;
            r_readdata <= '0;
        end else begin
            r_out      <= w_final;
            r_readdata <= w_rd_mux;
        end
    end

    assign out_port     = r_out;
    assign bus.readdata = r_readdata;
endmodule

// File: tb/tb_lt24_hires_led_out.sv
// Directed bench for lt24_hires_led_out (WIDTH=8, RESET_VALUE=8'h5A): register access, set/clear,
// blink timing, PERIOD overrides, mid-run reset and, when LT24_LED_OUT_PWM_EN is defined, PWM duty.
module tb_lt24_hires_led_out;
    localparam logic [7:0] RV = 8'h5A;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] out_port;
    int         n_vec = 0;
    int         n_err = 0;
    logic [31:0] rdv;

    lt24_hires_led_out_if bus ();

    lt24_hires_led_out #(
        .WIDTH       (8),
        .CNT_W       (24),
        .RESET_VALUE (RV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        tick();
        d = bus.readdata;
    endtask

    initial begin
        reset          = 1'b1;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        tick(); tick(); tick();
        check("reset_out", 32'(out_port), 32'h5A);
        check("reset_rdata", bus.readdata, 32'h0);
        reset = 1'b0;
        tick();
        check("post_reset_out", 32'(out_port), 32'h5A);
        rd(3'd0, rdv); check("rd_data_rv", rdv, 32'h5A);
        rd(3'd3, rdv); check("rd_status_rv", rdv, 32'h1);
`ifdef LT24_LED_OUT_PWM_EN
        rd(3'd6, rdv); check("rd_duty_rv", rdv, 32'hFF);
`else
        rd(3'd6, rdv); check("rd_addr6", rdv, 32'h0);
`endif

        // Data writes, set and clear strobes.
        wr(3'd0, 32'hFFFF_FFF0); tick(); check("out_data_f0", 32'(out_port), 32'hF0);
        wr(3'd4, 32'h03);        tick(); check("out_set_f3", 32'(out_port), 32'hF3);
        wr(3'd5, 32'h10);        tick(); check("out_clr_e3", 32'(out_port), 32'hE3);
        rd(3'd0, rdv); check("rd_data_e3", rdv, 32'hE3);
        rd(3'd4, rdv); check("rd_outset_0", rdv, 32'h0);

        // Unused address and unselected write must not touch DATA.
        wr(3'd7, 32'hFF);
        bus.address = 3'd0; bus.writedata = 32'h00; bus.write_n = 1'b0; bus.chipselect = 1'b0;
        tick();
        bus.write_n = 1'b1;
        rd(3'd0, rdv); check("rd_data_nowrite", rdv, 32'hE3);
        check("out_nowrite", 32'(out_port), 32'hE3);

        // Blink: low nibble 4 clocks on, 4 off.
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'h0F);
        wr(3'd2, 32'd4);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("blink_k%0d", k), 32'(out_port),
                  ((k <= 4) || (k > 8)) ? 32'hFF : 32'hF0);
        end
        rd(3'd3, rdv); check("status_phase0", rdv, 32'h2);
        check("out_phase0", 32'(out_port), 32'hF0);

        // PERIOD = 0 while phase is 0 forces solid output.
        wr(3'd2, 32'd0);
        check("out_p0_lag", 32'(out_port), 32'hF0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("hold_k%0d", k), 32'(out_port), 32'hFF);
        end
        rd(3'd3, rdv); check("status_p0", rdv, 32'h1);

        // PERIOD = 2 written on the expiry edge of a PERIOD = 4 half-cycle.
        wr(3'd2, 32'd4);
        tick(); tick(); tick();
        wr(3'd2, 32'd2);
        check("ovr_f4", 32'(out_port), 32'hFF);
        tick(); check("ovr_f5", 32'(out_port), 32'hFF);
        tick(); check("ovr_f6", 32'(out_port), 32'hFF);
        tick(); check("ovr_f7", 32'(out_port), 32'hF0);
        tick(); check("ovr_f8", 32'(out_port), 32'hF0);
        tick(); check("ovr_f9", 32'(out_port), 32'hFF);

        // PERIOD holds CNT_W bits only.
        wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2, rdv); check("rd_period_w", rdv, 32'h00FF_FFFF);
        wr(3'd2, 32'd3);

        // Mid-blink reset.
        tick(); tick();
        reset = 1'b1;
        tick();
        check("midrst_out", 32'(out_port), 32'h5A);
        reset = 1'b0;
        tick(); check("midrst_out2", 32'(out_port), 32'h5A);
        rd(3'd0, rdv); check("midrst_data", rdv, 32'h5A);
        rd(3'd1, rdv); check("midrst_blink", rdv, 32'h0);
        rd(3'd2, rdv); check("midrst_period", rdv, 32'h0);
        rd(3'd3, rdv); check("midrst_status", rdv, 32'h1);
        check("midrst_out3", 32'(out_port), 32'h5A);

`ifdef LT24_LED_OUT_PWM_EN
        begin
            int ones;
            wr(3'd0, 32'h01);
            wr(3'd6, 32'd64);
            rd(3'd6, rdv); check("rd_duty64", rdv, 32'd64);
            ones = 0;
            for (int k = 0; k < 256; k++) begin
                tick();
                ones += int'(out_port[0]);
            end
            check("pwm64_ones", 32'(ones), 32'd64);
            wr(3'd6, 32'd0);
            ones = 0;
            for (int k = 0; k < 256; k++) begin
                tick();
                ones += int'(out_port[0]);
            end
            check("pwm0_ones", 32'(ones), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
